// File: rtl/w_pkg.sv
// Shared definitions for the layer-4 weight loader: geometry, weight type and loader states.
package w_pkg;
  localparam int BANKS = 16;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = 8;

  typedef logic signed [DW-1:0] weight_t;

  typedef enum logic [1:0] {
    WL_IDLE  = 2'd0,
    WL_LOAD  = 2'd1,
    WL_CHECK = 2'd2,
    WL_DONE  = 2'd3
  } wl_state_t;

  function automatic logic [BANKS-1:0] bank_onehot(input logic [AW-1:0] idx);
    return BANKS'(1) << idx;
  endfunction
endpackage

// File: rtl/w_loader_if.sv
// Byte stream into the weight loader.
// Handshake: a byte transfers on a rising edge where s_valid && s_ready; s_ready
// comes from the receiver's state only and never depends on s_valid.
interface w_loader_if;
  import w_pkg::*;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/w_loader.sv
// Loads 256 weights plus a checksum byte into sixteen 16-entry banks through one
// registered write port, then pulses finish and reports checksum errors in err.
module w_loader
  import w_pkg::*;
(
  input  logic             clk,
  input  logic             xrst,
  input  logic             start,
  w_loader_if.slave        s,
  output logic [BANKS-1:0] we,
  output logic [AW-1:0]    waddr,
  output weight_t          wdata,
  output logic             busy,
  output logic             finish,
  output logic             err,
  output wl_state_t        dbg_state
);
  wl_state_t     state, state_nxt;
  logic [CW-1:0] cnt;
  logic [DW-1:0] sum;
  logic          hs;

  assign s.s_ready = (state == WL_LOAD) || (state == WL_CHECK);
  assign hs        = s.s_valid && s.s_ready;
  assign busy      = (state != WL_IDLE);
  assign finish    = (state == WL_DONE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      WL_IDLE:  if (start) state_nxt = WL_LOAD;
      WL_LOAD:  if (hs && (cnt == 8'hFF)) state_nxt = WL_CHECK;
      WL_CHECK: if (hs) state_nxt = WL_DONE;
      WL_DONE:  state_nxt = WL_IDLE;
      default:  state_nxt = WL_IDLE;
    endcase
  end

  // Byte n lands in bank n[3:0], entry n[7:4]: the stream is address-major.
  always_ff @(posedge clk) begin
    if (xrst) begin
      state <= WL_IDLE;
      cnt   <= '0;
      sum   <= '0;
      err   <= 1'b0;
      we    <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      state <= state_nxt;
      we    <= '0;
      if ((state == WL_IDLE) && start) begin
        cnt <= '0;
        sum <= '0;
        err <= 1'b0;
      end
      if ((state == WL_LOAD) && hs) begin
        we    <= bank_onehot(cnt[AW-1:0]);
        waddr <= cnt[CW-1:AW];
        wdata <= weight_t'(s.s_data);
        sum   <= sum + s.s_data;
        cnt   <= cnt + 8'd1;
      end
      if ((state == WL_CHECK) && hs) begin
        err <= (s.s_data != sum);
      end
    end
  end
endmodule
